// File: rtl/sys_instr_sequencer.sv
// Stall sequencer for FENCE/FENCE.I, ECALL and EBREAK: drains memory, injects bubbles, halts.
// Optional macro SYS_HALT_RESUME_EN lets a resume request release the HALT state.
module sys_instr_sequencer #(
  parameter int unsigned NOP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] opcode,
  input  logic       distin,
  input  logic       mem_busy,
  input  logic       resume,
  output logic       stall_pc,
  output logic       insert_nop,
  output logic       halted,
  output logic       seq_done,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StDrain  = 2'b01,
    StBubble = 2'b10,
    StHalt   = 2'b11
  } state_e;

  localparam logic [4:0] OpFence  = 5'b00011;
  localparam logic [4:0] OpSystem = 5'b11100;
  localparam logic [2:0] NopLoad  = 3'(NOP_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       halt_release;

`ifdef SYS_HALT_RESUME_EN
  assign halt_release = (state_q == StHalt) && resume;
`else
  logic unused_resume;
  assign unused_resume = resume;
  assign halt_release  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (id_valid) begin
          if (opcode == OpFence) begin
            state_d = StDrain;
          end else if (opcode == OpSystem) begin
            if (distin) begin
              state_d = StHalt;
            end else begin
              state_d = StBubble;
              cnt_d   = NopLoad;
            end
          end
        end
      end
      StDrain: begin
        if (!mem_busy) begin
          state_d = StBubble;
          cnt_d   = NopLoad;
        end
      end
      StBubble: begin
        // Exit on 1 (or an out-of-range 0) so the counter never wraps.
        if (cnt_q <= 3'd1) begin
          state_d = StRun;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StHalt: begin
        if (halt_release) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    stall_pc   = (state_q != StRun);
    insert_nop = (state_q != StRun);
    halted     = (state_q == StHalt);
    seq_done   = ((state_q == StBubble) && (cnt_q == 3'd1)) || halt_release;
    state_o    = state_q;
  end

endmodule

// File: tb/tb_sys_instr_sequencer.sv
// Directed bench for sys_instr_sequencer; three instances cover NOP_CYCLES = 1, 3 and 5.
module tb_sys_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] opcode = 5'b0;
  logic       distin = 1'b0;
  logic       mem_busy = 1'b0;
  logic       resume = 1'b0;

  logic       stall1, nop1, halt1, done1;
  logic       stall3, nop3, halt3, done3;
  logic       stall5, nop5, halt5, done5;
  logic [1:0] st1, st3, st5;

  // Packed view: {stall_pc, insert_nop, halted, seq_done, state_o}
  wire [5:0] o1 = {stall1, nop1, halt1, done1, st1};
  wire [5:0] o3 = {stall3, nop3, halt3, done3, st3};
  wire [5:0] o5 = {stall5, nop5, halt5, done5, st5};

  localparam logic [5:0] ORun   = 6'b0000_00;
  localparam logic [5:0] ODrain = 6'b1100_01;
  localparam logic [5:0] OBub   = 6'b1100_10;
  localparam logic [5:0] OLast  = 6'b1101_10;
  localparam logic [5:0] OHalt  = 6'b1110_11;
  localparam logic [5:0] ORel   = 6'b1111_11;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  sys_instr_sequencer #(.NOP_CYCLES(1)) u_n1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .distin(distin),
    .mem_busy(mem_busy), .resume(resume), .stall_pc(stall1), .insert_nop(nop1),
    .halted(halt1), .seq_done(done1), .state_o(st1)
  );
  sys_instr_sequencer #(.NOP_CYCLES(3)) u_n3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .distin(distin),
    .mem_busy(mem_busy), .resume(resume), .stall_pc(stall3), .insert_nop(nop3),
    .halted(halt3), .seq_done(done3), .state_o(st3)
  );
  sys_instr_sequencer #(.NOP_CYCLES(5)) u_n5 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .distin(distin),
    .mem_busy(mem_busy), .resume(resume), .stall_pc(stall5), .insert_nop(nop5),
    .halted(halt5), .seq_done(done5), .state_o(st5)
  );

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_valid = 1'b0;
    mem_busy = 1'b0;
    resume = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic present(input logic [4:0] op, input logic d, input logic v);
    opcode = op;
    distin = d;
    id_valid = v;
  endtask

  initial begin
    logic [5:0] exp_fence [8];
    logic [5:0] exp_n5 [6];
    logic [5:0] exp_dbl [4];
    logic       busy_drv [8];
    exp_fence = '{ODrain, ODrain, ODrain, ODrain, OBub, OBub, OLast, ORun};
    busy_drv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_n5    = '{OBub, OBub, OBub, OBub, OLast, ORun};
    exp_dbl   = '{OBub, OBub, OLast, ORun};

    // Reset state, with inputs trying to start a sequence and hold DRAIN
    present(5'b11100, 1'b1, 1'b1);
    rst = 1'b1;
    mem_busy = 1'b1;
    resume = 1'b1;
    step();
    check("reset_n1", o1, ORun);
    check("reset_n3", o3, ORun);
    check("reset_n5", o5, ORun);
    do_reset();

    // ECALL with NOP_CYCLES=1: single bubble carrying seq_done
    present(5'b11100, 1'b0, 1'b1);
    step();
    id_valid = 1'b0;
    check("ecall1_t1", o1, OLast);
    step();
    check("ecall1_t2", o1, ORun);

    // FENCE with NOP_CYCLES=3 and mem_busy held for 4 DRAIN cycles; toggles in BUBBLE ignored
    do_reset();
    present(5'b00011, 1'b0, 1'b1);
    mem_busy = 1'b1;
    step();
    id_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fence3_c%0d", i + 1), o3, exp_fence[i]);
      mem_busy = busy_drv[i];
      step();
    end

    // EBREAK halts; resume behaviour depends on build option
    do_reset();
    present(5'b11100, 1'b1, 1'b1);
    step();
    id_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("ebreak_t%0d", i), o3, OHalt);
      step();
    end
`ifdef SYS_HALT_RESUME_EN
    resume = 1'b1;
    #1;
    check("ebreak_resume_t5", o3, ORel);
    step();
    resume = 1'b0;
    check("ebreak_resume_t6", o3, ORun);
`else
    resume = 1'b1;
    #1;
    check("ebreak_resume_ignored", o3, OHalt);
    step();
    resume = 1'b0;
    for (int i = 6; i <= 20; i++) begin
      check($sformatf("ebreak_hold_t%0d", i), o3, OHalt);
      step();
    end
`endif

    // Reset in the 2nd bubble cycle with NOP_CYCLES=5, then a clean ECALL
    do_reset();
    present(5'b11100, 1'b0, 1'b1);
    step();
    id_valid = 1'b0;
    check("rstbub_c1", o5, OBub);
    step();
    check("rstbub_c2", o5, OBub);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstbub_after", o5, ORun);
    present(5'b11100, 1'b0, 1'b1);
    step();
    id_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rstbub_ecall_c%0d", i + 1), o5, exp_n5[i]);
      step();
    end

    // ECALL with id_valid=0 is ignored; a second ECALL during BUBBLE does not extend the stall
    do_reset();
    present(5'b11100, 1'b0, 1'b0);
    step();
    check("ecall_invalid", o3, ORun);
    id_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ecall_dbl_c%0d", i + 1), o3, exp_dbl[i]);
      if (i == 2) id_valid = 1'b0;
      step();
    end
    check("ecall_dbl_idle", o3, ORun);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
